// File: rtl/riscv_pkg.sv
// Shared RV32I widths used by the register file, writeback and decode stages.
// REG_ZERO names the hardwired-zero register x0.
package riscv_pkg;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int REG_AW = $clog2(NREGS);

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational register-file read port.
// Handles the x0 / out-of-range check, the W->D bypass and the array mux.
module regfile_read_port #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [AW-1:0]              wr_addr,
  input  logic [XLEN-1:0]            wr_data,
  input  logic [NREGS-1:0][XLEN-1:0] regs,
  input  logic [AW-1:0]              rd_addr,
  output logic [XLEN-1:0]            rd_data
);

  localparam logic [AW:0] NLIM = (AW+1)'(NREGS);

  logic zero_hit;
  logic byp_hit;

  assign zero_hit = (rd_addr == '0) ||
                    ({1'b0, rd_addr} >= NLIM);

  // Exclusive with zero_hit so the decoder stays one-hot.
  assign byp_hit = BYPASS && !zero_hit && !rst &&
                   wr_en && (wr_addr == rd_addr);

  always_comb begin
    rd_data = '0;
    unique case (1'b1)
      zero_hit: rd_data = '0;
      byp_hit:  rd_data = wr_data;
      default:  rd_data = regs[rd_addr];
    endcase
  end

endmodule

// File: rtl/register_file.sv
// RV32I integer register file: two combinational read ports for decode,
// one write port from writeback, x0 hardwired to zero.
module register_file #(
  parameter int XLEN   = riscv_pkg::XLEN,
  parameter int NREGS  = riscv_pkg::NREGS,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_register_file_wr_en_W,
  input  logic [AW-1:0]   i_register_file_wr_addr_W,
  input  logic [XLEN-1:0] i_result_W,
  input  logic [AW-1:0]   i_rd_addr1_D,
  input  logic [AW-1:0]   i_rd_addr2_D,
  output logic [XLEN-1:0] o_rd_data1_D,
  output logic [XLEN-1:0] o_rd_data2_D
);

  import riscv_pkg::*;

  localparam logic [AW:0] NLIM = (AW+1)'(NREGS);

  // x0 has no storage; slot 0 of the read view is a constant zero.
  logic [NREGS-1:1][XLEN-1:0] mem;
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic                       wr_ok;

  assign regs = {mem, XLEN'(0)};

  assign wr_ok = i_register_file_wr_en_W &&
                 (i_register_file_wr_addr_W != AW'(REG_ZERO)) &&
                 ({1'b0, i_register_file_wr_addr_W} < NLIM);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_ok) begin
      mem[i_register_file_wr_addr_W] <= i_result_W;
    end
  end

  regfile_read_port #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rp1 (
    .rst     (rst),
    .wr_en   (i_register_file_wr_en_W),
    .wr_addr (i_register_file_wr_addr_W),
    .wr_data (i_result_W),
    .regs    (regs),
    .rd_addr (i_rd_addr1_D),
    .rd_data (o_rd_data1_D)
  );

  regfile_read_port #(
    .XLEN   (XLEN),
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_rp2 (
    .rst     (rst),
    .wr_en   (i_register_file_wr_en_W),
    .wr_addr (i_register_file_wr_addr_W),
    .wr_data (i_result_W),
    .regs    (regs),
    .rd_addr (i_rd_addr2_D),
    .rd_data (o_rd_data2_D)
  );

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: BYPASS=1 and BYPASS=0 instances
// share stimulus; expected reads are queued and checked by a monitor.
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [4:0]  wa;
  logic [31:0] wd;
  logic [4:0]  ra1;
  logic [4:0]  ra2;
  logic [31:0] b1, b2, n1, n2;

  always #5 clk = ~clk;

  register_file #(.BYPASS(1'b1)) dut_b (
    .clk                       (clk),
    .rst                       (rst),
    .i_register_file_wr_en_W   (we),
    .i_register_file_wr_addr_W (wa),
    .i_result_W                (wd),
    .i_rd_addr1_D              (ra1),
    .i_rd_addr2_D              (ra2),
    .o_rd_data1_D              (b1),
    .o_rd_data2_D              (b2)
  );

  register_file #(.BYPASS(1'b0)) dut_n (
    .clk                       (clk),
    .rst                       (rst),
    .i_register_file_wr_en_W   (we),
    .i_register_file_wr_addr_W (wa),
    .i_result_W                (wd),
    .i_rd_addr1_D              (ra1),
    .i_rd_addr2_D              (ra2),
    .o_rd_data1_D              (n1),
    .o_rd_data2_D              (n2)
  );

  typedef struct {
    string       tag;
    logic [31:0] eb1, eb2, en1, en2;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m[32];
  int          tests = 0;
  int          fails = 0;

  function automatic logic [31:0] rd_model(
    input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'h0;
    if (byp && we && !rst && wa == a) return wd;
    return m[a];
  endfunction

  // Drive one cycle just after the edge; queue expectations, then
  // advance the model to the state after the next edge.
  task automatic cyc(
    input logic r, input logic w, input logic [4:0] a,
    input logic [31:0] d, input logic [4:0] x1,
    input logic [4:0] x2, input string tag, input bit chk = 1'b1);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; we = w; wa = a; wd = d; ra1 = x1; ra2 = x2;
    if (chk) begin
      e.tag = tag;
      e.eb1 = rd_model(x1, 1'b1);
      e.eb2 = rd_model(x2, 1'b1);
      e.en1 = rd_model(x1, 1'b0);
      e.en2 = rd_model(x2, 1'b0);
      q.push_back(e);
    end
    if (r) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
    end else if (w && a != 5'd0) begin
      m[a] = d;
    end
  endtask

  task automatic check(input string tag, input string port,
                       input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s %s: got %h expected %h", tag, port, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check(e.tag, "byp.rd1", b1, e.eb1);
      check(e.tag, "byp.rd2", b2, e.eb2);
      check(e.tag, "nobyp.rd1", n1, e.en1);
      check(e.tag, "nobyp.rd2", n2, e.en2);
    end
  end

  initial begin
    logic [4:0]  a, x1, x2;
    logic        w, r;
    logic [31:0] d;
    int          guard;
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
    for (int i = 0; i < 32; i++) m[i] = 32'h0;

    // Contents are unknown before the first reset edge.
    cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2, "reset", 1'b0);
    for (int i = 1; i < 32; i++)
      cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(32 - i), "reset_read");

    cyc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd1, 5'd2, "wr_x5");
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd6, "rd_x5_x6");

    cyc(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, "x0_same");
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "x0_next");

    cyc(1'b0, 1'b1, 5'd7, 32'h11, 5'd0, 5'd0, "wr_x7");
    cyc(1'b0, 1'b1, 5'd7, 32'h22, 5'd7, 5'd7, "bypass_x7");
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, "after_x7");

    cyc(1'b0, 1'b1, 5'd9, 32'hAAAA0000, 5'd0, 5'd0, "wr_x9");
    cyc(1'b1, 1'b1, 5'd9, 32'h55, 5'd9, 5'd9, "rst_vs_wr");
    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5, "after_rst");

    cyc(1'b0, 1'b1, 5'd31, 32'hFFFFFFFF, 5'd31, 5'd30, "x31_byp");
    cyc(1'b0, 1'b0, 5'd31, 32'h0, 5'd31, 5'd0, "x31_we0");

    for (int i = 0; i < 10000; i++) begin
      r  = ($urandom_range(0, 499) == 0);
      w  = ($urandom_range(0, 3) != 0);
      a  = 5'($urandom_range(0, 31));
      d  = $urandom();
      x1 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      x2 = ($urandom_range(0, 3) == 0) ? a : 5'($urandom_range(0, 31));
      cyc(r, w, a, d, x1, x2, "random");
    end

    cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, "idle", 1'b0);
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
